// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: a Moore FSM that sequences fetch, decode and execute
// and drives every datapath load enable, mux select and memory request.
module control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_en,
    input  logic       mem_resp,
    input  logic [1:0] addr_lsb,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_data_out,
    output logic [1:0] pcmux_sel,
    output logic       alumux1_sel,
    output logic [2:0] alumux2_sel,
    output logic [3:0] regfilemux_sel,
    output logic       marmux_sel,
    output logic       cmpmux_sel,
    output logic [2:0] aluop,
    output logic [2:0] cmpop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_enable
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SRA = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_SRL = 3'd5;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] CMP_BLT  = 3'b100;
    localparam logic [2:0] CMP_BLTU = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE, S_IMM, S_REG, S_BR, S_LUI,
        S_AUIPC, S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2, S_JAL, S_JALR
    } state_e;

    state_e state_q, state_d;

    // Only funct7[5] distinguishes sub/sra from add/srl.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = 2'd0;
        alumux1_sel     = 1'b0;
        alumux2_sel     = 3'd0;
        regfilemux_sel  = 4'd0;
        marmux_sel      = 1'b0;
        cmpmux_sel      = 1'b0;
        aluop           = ALU_ADD;
        cmpop           = 3'd0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'b1111;

        case (state_q)
            S_FETCH1: begin
                load_mar = 1'b1;
                state_d  = S_FETCH2;
            end
            S_FETCH2: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
                if (mem_resp) state_d = S_FETCH3;
            end
            S_FETCH3: begin
                load_ir = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_IMM:            state_d = S_IMM;
                    OP_REG:            state_d = S_REG;
                    OP_BR:             state_d = S_BR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    OP_LOAD, OP_STORE: state_d = S_CALC_ADDR;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default: begin
                        // Unrecognised instruction: skip it by advancing pc only.
                        load_pc = 1'b1;
                        state_d = S_FETCH1;
                    end
                endcase
            end
            S_IMM, S_REG: begin
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                state_d      = S_FETCH1;
                if (state_q == S_REG) alumux2_sel = 3'd5;
                if (funct3 == F3_SLT || funct3 == F3_SLTU) begin
                    cmpmux_sel     = (state_q == S_IMM);
                    cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                    regfilemux_sel = 4'd1;
                end else if (funct3 == F3_ADD) begin
                    aluop = (state_q == S_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
                end else if (funct3 == F3_SR) begin
                    aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                end else begin
                    aluop = funct3;
                end
            end
            S_BR: begin
                cmpop       = funct3;
                alumux1_sel = 1'b1;
                alumux2_sel = 3'd2;
                load_pc     = 1'b1;
                pcmux_sel   = {1'b0, br_en};
                state_d     = S_FETCH1;
            end
            S_LUI: begin
                load_regfile   = 1'b1;
                regfilemux_sel = 4'd2;
                load_pc        = 1'b1;
                state_d        = S_FETCH1;
            end
            S_AUIPC: begin
                alumux1_sel  = 1'b1;
                alumux2_sel  = 3'd1;
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                state_d      = S_FETCH1;
            end
            S_CALC_ADDR: begin
                load_mar   = 1'b1;
                marmux_sel = 1'b1;
                if (opcode == OP_STORE) begin
                    alumux2_sel   = 3'd3;
                    load_data_out = 1'b1;
                    state_d       = S_ST1;
                end else begin
                    state_d = S_LD1;
                end
            end
            S_LD1: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
                if (mem_resp) state_d = S_LD2;
            end
            S_LD2: begin
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                state_d      = S_FETCH1;
                case (funct3)
                    3'b000:  regfilemux_sel = 4'd5;
                    3'b001:  regfilemux_sel = 4'd7;
                    3'b010:  regfilemux_sel = 4'd3;
                    3'b100:  regfilemux_sel = 4'd6;
                    3'b101:  regfilemux_sel = 4'd8;
                    default: regfilemux_sel = 4'd0;
                endcase
            end
            S_ST1: begin
                mem_write = 1'b1;
                if (mem_resp) state_d = S_ST2;
                case (funct3)
                    3'b000:  mem_byte_enable = 4'b0001 << addr_lsb;
                    3'b001:  mem_byte_enable = 4'b0011 << {addr_lsb[1], 1'b0};
                    default: mem_byte_enable = 4'b1111;
                endcase
            end
            S_ST2: begin
                load_pc = 1'b1;
                state_d = S_FETCH1;
            end
            S_JAL: begin
                regfilemux_sel = 4'd4;
                load_regfile   = 1'b1;
                alumux1_sel    = 1'b1;
                alumux2_sel    = 3'd4;
                load_pc        = 1'b1;
                pcmux_sel      = 2'd1;
                state_d        = S_FETCH1;
            end
            S_JALR: begin
                regfilemux_sel = 4'd4;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                pcmux_sel      = 2'd2;
                state_d        = S_FETCH1;
            end
            default: state_d = S_FETCH1;
        endcase

        // Reset must never let a register load or a memory request escape.
        if (rst) begin
            load_pc       = 1'b0;
            load_ir       = 1'b0;
            load_regfile  = 1'b0;
            load_mar      = 1'b0;
            load_mdr      = 1'b0;
            load_data_out = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
        end
    end
endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed instruction scenarios followed by
// randomized instruction streams, all compared every cycle against a behavioural model.
module tb_control_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       br_en = 1'b0;
    logic       mem_resp = 1'b0;
    logic [1:0] addr_lsb = 2'd0;
    logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    logic [1:0] pcmux_sel;
    logic       alumux1_sel;
    logic [2:0] alumux2_sel;
    logic [3:0] regfilemux_sel;
    logic       marmux_sel, cmpmux_sel;
    logic [2:0] aluop, cmpop;
    logic       mem_read, mem_write;
    logic [3:0] mem_byte_enable;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .mem_resp(mem_resp), .addr_lsb(addr_lsb),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
        .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
        .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
        .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
        .aluop(aluop), .cmpop(cmpop), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable)
    );

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    // Model steps: where the instruction currently is in its life cycle.
    localparam int M_F1 = 0, M_F2 = 1, M_F3 = 2, M_DEC = 3, M_IMM = 4, M_REG = 5, M_BR = 6;
    localparam int M_LUI = 7, M_AUIPC = 8, M_CALC = 9, M_LD1 = 10, M_LD2 = 11, M_ST1 = 12;
    localparam int M_ST2 = 13, M_JAL = 14, M_JALR = 15;

    int n_total = 0;
    int n_pass = 0;
    int cyc = 0;
    int m_step = M_F1;

    function automatic int exec_step(input logic [6:0] op);
        case (op)
            OP_IMM:       return M_IMM;
            OP_REG:       return M_REG;
            OP_BR:        return M_BR;
            OP_LUI:       return M_LUI;
            OP_AUIPC:     return M_AUIPC;
            OP_LD, OP_ST: return M_CALC;
            OP_JAL:       return M_JAL;
            OP_JALR:      return M_JALR;
            default:      return M_F1;
        endcase
    endfunction

    function automatic int next_of(input int s, input logic [6:0] op, input logic resp);
        case (s)
            M_F1:    return M_F2;
            M_F2:    return resp ? M_F3 : M_F2;
            M_F3:    return M_DEC;
            M_DEC:   return exec_step(op);
            M_CALC:  return (op == OP_ST) ? M_ST1 : M_LD1;
            M_LD1:   return resp ? M_LD2 : M_LD1;
            M_ST1:   return resp ? M_ST2 : M_ST1;
            default: return M_F1;
        endcase
    endfunction

    // ALU operation named by the instruction mnemonic: add0 sll1 sra2 sub3 xor4 srl5 or6 and7.
    function automatic int alu_code(input bit is_reg, input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'd0:    return (is_reg && f7[5]) ? 3 : 0;
            3'd1:    return 1;
            3'd4:    return 4;
            3'd5:    return f7[5] ? 2 : 5;
            3'd6:    return 6;
            3'd7:    return 7;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic compare_all();
        int lpc = 0, lir = 0, lrf = 0, lmar = 0, lmdr = 0, ldo = 0, pcm = 0, am1 = 0, am2 = 0;
        int rfm = 0, marm = 0, cmpm = 0, alu = 0, cop = 0, mrd = 0, mwr = 0, mbe = 15;
        case (m_step)
            M_F1: lmar = 1;
            M_F2, M_LD1: begin mrd = 1; lmdr = 1; end
            M_F3: lir = 1;
            M_DEC: if (exec_step(opcode) == M_F1) lpc = 1;
            M_IMM, M_REG: begin
                lrf = 1; lpc = 1;
                if (m_step == M_REG) am2 = 5;
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    rfm = 1;
                    cmpm = (m_step == M_IMM) ? 1 : 0;
                    cop = (funct3 == 3'd2) ? 4 : 6;
                end else begin
                    alu = alu_code(m_step == M_REG, funct3, funct7);
                end
            end
            M_BR: begin cop = funct3; am1 = 1; am2 = 2; lpc = 1; pcm = br_en ? 1 : 0; end
            M_LUI: begin lrf = 1; rfm = 2; lpc = 1; end
            M_AUIPC: begin am1 = 1; am2 = 1; lrf = 1; lpc = 1; end
            M_CALC: begin
                lmar = 1; marm = 1;
                if (opcode == OP_ST) begin am2 = 3; ldo = 1; end
            end
            M_LD2: begin
                lrf = 1; lpc = 1;
                case (funct3)
                    3'd0: rfm = 5; 3'd1: rfm = 7; 3'd2: rfm = 3; 3'd4: rfm = 6; 3'd5: rfm = 8;
                    default: rfm = 0;
                endcase
            end
            M_ST1: begin
                mwr = 1;
                if (funct3 == 3'd0) mbe = 1 << addr_lsb;
                else if (funct3 == 3'd1) mbe = addr_lsb[1] ? 12 : 3;
            end
            M_ST2: lpc = 1;
            M_JAL: begin rfm = 4; lrf = 1; am1 = 1; am2 = 4; lpc = 1; pcm = 1; end
            M_JALR: begin rfm = 4; lrf = 1; lpc = 1; pcm = 2; end
            default: ;
        endcase
        if (rst) begin lpc = 0; lir = 0; lrf = 0; lmar = 0; lmdr = 0; ldo = 0; mrd = 0; mwr = 0; end
        chk("load_pc", load_pc, lpc);               chk("load_ir", load_ir, lir);
        chk("load_regfile", load_regfile, lrf);     chk("load_mar", load_mar, lmar);
        chk("load_mdr", load_mdr, lmdr);            chk("load_data_out", load_data_out, ldo);
        chk("pcmux_sel", pcmux_sel, pcm);           chk("alumux1_sel", alumux1_sel, am1);
        chk("alumux2_sel", alumux2_sel, am2);       chk("regfilemux_sel", regfilemux_sel, rfm);
        chk("marmux_sel", marmux_sel, marm);        chk("cmpmux_sel", cmpmux_sel, cmpm);
        chk("aluop", aluop, alu);                   chk("cmpop", cmpop, cop);
        chk("mem_read", mem_read, mrd);             chk("mem_write", mem_write, mwr);
        chk("mem_byte_enable", mem_byte_enable, mbe);
        chk("rw_exclusive", int'(mem_read && mem_write), 0);
    endtask

    // One clock: advance the model on the inputs seen at the edge, drive new inputs, compare.
    task automatic tick(input logic r, input logic mr, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic be, input logic [1:0] al);
        @(posedge clk);
        #1;
        m_step = rst ? M_F1 : next_of(m_step, opcode, mem_resp);
        cyc++;
        rst = r; mem_resp = mr; opcode = op; funct3 = f3; funct7 = f7; br_en = be; addr_lsb = al;
        #1;
        compare_all();
    endtask

    // From a terminal state: FETCH1, FETCH2 (memory answers at once), FETCH3, DECODE.
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3);
        tick(1'b0, 1'b0, op, f3, 7'd0, 1'b0, 2'd0);
        tick(1'b0, 1'b1, op, f3, 7'd0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, op, f3, 7'd0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, op, f3, 7'd0, 1'b0, 2'd0);
    endtask

    initial begin
        int rd_cycles;
        logic [6:0] cur_op, cur_f7;
        logic [2:0] cur_f3;
        logic [6:0] op_table [9];
        op_table = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_REG};

        // Reset, then a fetch whose memory answers in the third FETCH2 cycle.
        tick(1'b1, 1'b0, OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0);
        tick(1'b1, 1'b0, OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0);
        chk("rst_load_mar", load_mar, 0);
        tick(1'b0, 1'b0, OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0);
        chk("post_rst_fetch1_load_mar", load_mar, 1);
        rd_cycles = 0;
        tick(1'b0, 1'b0, OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0); rd_cycles += int'(mem_read);
        tick(1'b0, 1'b0, OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0); rd_cycles += int'(mem_read);
        tick(1'b0, 1'b1, OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0); rd_cycles += int'(mem_read);
        tick(1'b0, 1'b0, OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0); rd_cycles += int'(mem_read);
        chk("fetch_read_cycles", rd_cycles, 3);
        chk("fetch3_load_ir", load_ir, 1);
        // addi
        tick(1'b0, 1'b0, OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, OP_IMM, 3'd0, 7'd0, 1'b0, 2'd0);
        chk("addi_aluop", aluop, 0);
        chk("addi_regfilemux", regfilemux_sel, 0);
        chk("addi_load_regfile", load_regfile, 1);
        chk("addi_load_pc", load_pc, 1);
        // sb to byte lane 2
        fetch(OP_ST, 3'd0);
        tick(1'b0, 1'b0, OP_ST, 3'd0, 7'd0, 1'b0, 2'd2);
        chk("sb_calc_load_data_out", load_data_out, 1);
        tick(1'b0, 1'b0, OP_ST, 3'd0, 7'd0, 1'b0, 2'd2);
        chk("sb_byte_enable", mem_byte_enable, 4);
        tick(1'b0, 1'b0, OP_ST, 3'd0, 7'd0, 1'b0, 2'd2);
        tick(1'b0, 1'b1, OP_ST, 3'd0, 7'd0, 1'b0, 2'd2);
        chk("sb_write_held", mem_write, 1);
        tick(1'b0, 1'b0, OP_ST, 3'd0, 7'd0, 1'b0, 2'd2);
        chk("sb_st2_load_pc", load_pc, 1);
        chk("sb_st2_write_low", mem_write, 0);
        // beq taken / not taken
        fetch(OP_BR, 3'd0);
        tick(1'b0, 1'b0, OP_BR, 3'd0, 7'd0, 1'b1, 2'd0);
        chk("beq_taken_pcmux", pcmux_sel, 1);
        chk("beq_load_pc", load_pc, 1);
        chk("beq_load_regfile", load_regfile, 0);
        fetch(OP_BR, 3'd0);
        tick(1'b0, 1'b0, OP_BR, 3'd0, 7'd0, 1'b0, 2'd0);
        chk("beq_not_taken_pcmux", pcmux_sel, 0);
        // lhu with a two-cycle memory wait
        fetch(OP_LD, 3'd5);
        tick(1'b0, 1'b0, OP_LD, 3'd5, 7'd0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, OP_LD, 3'd5, 7'd0, 1'b0, 2'd0);
        chk("lhu_ld1_read", mem_read, 1);
        tick(1'b0, 1'b1, OP_LD, 3'd5, 7'd0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, OP_LD, 3'd5, 7'd0, 1'b0, 2'd0);
        chk("lhu_regfilemux", regfilemux_sel, 8);
        // reset in the middle of a load wait
        fetch(OP_LD, 3'd2);
        tick(1'b0, 1'b0, OP_LD, 3'd2, 7'd0, 1'b0, 2'd0);
        tick(1'b0, 1'b0, OP_LD, 3'd2, 7'd0, 1'b0, 2'd0);
        tick(1'b1, 1'b0, OP_LD, 3'd2, 7'd0, 1'b0, 2'd0);
        chk("ld1_rst_read_low", mem_read, 0);
        tick(1'b0, 1'b0, OP_LD, 3'd2, 7'd0, 1'b0, 2'd0);
        chk("ld1_rst_fetch1", load_mar, 1);
        chk("ld1_rst_fetch1_read", mem_read, 0);

        // Randomized instruction stream with random memory latency and occasional reset.
        cur_op = OP_IMM; cur_f3 = 3'd0; cur_f7 = 7'd0;
        for (int i = 0; i < 4000; i++) begin
            if (m_step == M_F1) begin
                cur_op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_table[$urandom_range(0, 8)];
                cur_f3 = 3'($urandom);
                cur_f7 = 7'($urandom);
            end
            tick(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 2) == 0), cur_op, cur_f3,
                 cur_f7, 1'($urandom), 2'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL have these inputs:
- opcode  in  7  IR opcode.
- funct3  in  3  IR funct3.
- funct7  in  7  IR funct7.
- br_en  in  1  comparator result.
- mem_resp  in  1  memory done, one-cycle pulse.
- addr_lsb  in  2  mar_out[1:0], valid in LD2/ST1.
REQ-003 The block SHALL drive these load enables:
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  datapath register loads.
REQ-004 The block SHALL drive these mux selects:
- pcmux_sel  out  2  0 pc+4, 1 alu_out, 2 alu_out&~1.
- alumux1_sel  out  1  0 rs1, 1 pc.
- alumux2_sel  out  3  0 i_imm, 1 u_imm, 2 b_imm, 3 s_imm, 4 j_imm, 5 rs2.
- regfilemux_sel  out  4  0 alu, 1 br_en, 2 u_imm, 3 lw, 4 pc+4, 5 lb, 6 lbu, 7 lh, 8 lhu.
- marmux_sel  out  1  0 pc, 1 alu_out.
- cmpmux_sel  out  1  0 rs2, 1 i_imm.
REQ-005 The block SHALL drive these operation and memory outputs:
- aluop  out  3  add, sll, sra, sub, xor, srl, or, and (0-7).
- cmpop  out  3  funct3 encoding (beq..bgeu).
- mem_read, mem_write  out  1  memory request.
- mem_byte_enable  out  4  store lanes.

Function
REQ-006 The block SHALL be a Moore FSM with states FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, BR, LUI, AUIPC, CALC_ADDR, LD1, LD2, ST1, ST2, JAL, JALR; all outputs SHALL be decoded from the registered state plus the opcode/funct inputs only.
REQ-007 In every state, each output not named for that state SHALL be 0, except mem_byte_enable, which SHALL default to 4'b1111.
REQ-008 FETCH1: load_mar=1, marmux_sel=0; next state FETCH2.
REQ-009 FETCH2: mem_read=1, load_mdr=1; hold FETCH2 while mem_resp=0; go to FETCH3 in the cycle mem_resp=1.
REQ-010 FETCH3: load_ir=1; next state DECODE.
REQ-011 DECODE SHALL branch on opcode: op_imm->IMM, op_reg->REG, br->BR, lui->LUI, auipc->AUIPC, load/store->CALC_ADDR, jal->JAL, jalr->JALR; any other opcode SHALL go to FETCH1 with no register update except load_pc=1, pcmux_sel=0.
REQ-012 IMM: load_regfile=1, load_pc=1, pcmux_sel=0.
- slti/sltiu: cmpmux_sel=1, cmpop=blt/bltu, regfilemux_sel=1.
- srai (funct3=101, funct7[5]=1): aluop=sra.
- All others: aluop=funct3, alumux2_sel=0, regfilemux_sel=0.
REQ-013 REG: same as IMM but with alumux2_sel=5 and cmpmux_sel=0; funct3=000 with funct7[5]=1 SHALL select sub; funct3=101 with funct7[5]=1 SHALL select sra.
REQ-014 BR: cmpop=funct3, cmpmux_sel=0, alumux1_sel=1, alumux2_sel=2, aluop=add, load_pc=1, pcmux_sel=br_en.
REQ-015 LUI: load_regfile=1, regfilemux_sel=2, load_pc=1.
REQ-016 AUIPC: alumux1_sel=1, alumux2_sel=1, aluop=add, load_regfile=1, load_pc=1.
REQ-017 CALC_ADDR: aluop=add, load_mar=1, marmux_sel=1.
- Load: alumux2_sel=0; next state LD1.
- Store: alumux2_sel=3, load_data_out=1; next state ST1.
REQ-018 LD1: mem_read=1, load_mdr=1; hold until mem_resp; then go to LD2.
REQ-019 LD2: load_regfile=1, load_pc=1; regfilemux_sel per funct3 (lb=5, lh=7, lw=3, lbu=6, lhu=8); byte/half lane selection via addr_lsb is done in the datapath.
REQ-020 ST1: mem_write=1; hold until mem_resp; then go to ST2.
- mem_byte_enable = sb: 4'b0001<<addr_lsb; sh: 4'b0011<<{addr_lsb[1],1'b0}; sw: 4'b1111.
REQ-021 ST2: load_pc=1, pcmux_sel=0.
REQ-022 JAL: regfilemux_sel=4, load_regfile=1, alumux1_sel=1, alumux2_sel=4, aluop=add, load_pc=1, pcmux_sel=1.
REQ-023 JALR: regfilemux_sel=4, load_regfile=1, alumux1_sel=0, alumux2_sel=0, aluop=add, load_pc=1, pcmux_sel=2.
REQ-024 All execute-terminal states (IMM, REG, BR, LUI, AUIPC, LD2, ST2, JAL, JALR) SHALL go to FETCH1.
REQ-025 mem_read and mem_write SHALL never be asserted in the same cycle; each SHALL stay high continuously until the cycle mem_resp is sampled high.
REQ-026 mem_resp arriving in any state other than FETCH2/LD1/ST1 SHALL be ignored.

Reset
REQ-027 With rst=1 at a clock edge, the next state SHALL be FETCH1 regardless of the current state, including mid-wait in FETCH2, LD1 or ST1.
REQ-028 While rst is high, all load_* signals and mem_read/mem_write SHALL be 0.
REQ-029 The first cycle after rst deasserts SHALL show FETCH1 outputs.

Verification
REQ-030 Reset, then mem_resp at 3rd FETCH2 cycle -> mem_read high for exactly 3 cycles, load_ir the following cycle.
REQ-031 addi (opcode 0010011, funct3 000) -> IMM: aluop=add, regfilemux_sel=0, load_regfile=1, load_pc=1, then FETCH1.
REQ-032 sb with addr_lsb=2'b10 -> ST1 mem_byte_enable=4'b0100, mem_write held until mem_resp, ST2 load_pc=1.
REQ-033 beq with br_en=1 -> BR pcmux_sel=1, load_pc=1, load_regfile=0; with br_en=0 -> pcmux_sel=0.
REQ-034 lhu (funct3 101) -> CALC_ADDR, LD1 (2-cycle wait), LD2 regfilemux_sel=8.
REQ-035 rst asserted in LD1 with mem_resp low -> next cycle FETCH1, mem_read=0 while rst=1.
